x_mux_trigger_multi: RTL and testbench

//  Parametrised N-channel successor to the dual mux-trigger delay-line core. Sits between
//  x_testbench (32-bit ctrl in, 32-bit status out over UART) and P_CHANNELS muxed delay

---
 rtl/x_mux_trigger_multi.sv | 236 +++++++++++++++++++++++
 tb/tb_x_mux_trigger_multi.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/x_mux_trigger_multi.sv
// N-channel mux-trigger delay-line core: repeated launch/capture trials on
// selected taps, reported as count, race or sweep results.
//
// state  | meaning
// IDLE   | wait for command toggle to differ from done toggle
// ARM    | launch held low for P_SETTLE cycles
// FIRE   | launch high; capture flops sample selected taps at the exit edge
// CAPT   | captured values settle in capture flops
// ACC    | accumulate hit counters, decrement remaining trials
// NEXT   | sweep only: stop on first missing tap or advance to next tap
// DONE   | publish result, return done toggle, clear busy
module x_mux_trigger_multi #(
  parameter int P_CHANNELS = 4,
  parameter int P_TAPS     = 64,
  parameter int P_SETTLE   = 4,
  parameter int P_SIM_PS   = 100,
  parameter int P_CLK_PS   = 10417
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_data,
  output logic [31:0] o_data
);

  localparam int SW = (P_SETTLE > 1) ? $clog2(P_SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(P_SETTLE - 1);
  localparam logic [6:0]    TAP_LAST    = 7'(P_TAPS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_FIRE, S_CAPT, S_ACC, S_NEXT, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          tog_q, tog_d;
  logic [1:0]    mode_q, mode_d;
  logic [2:0]    cha_q, cha_d;
  logic [2:0]    chb_q, chb_d;
  logic [15:0]   tcnt_q, tcnt_d;
  logic          err_q, err_d;
  logic          zero_q, zero_d;
  logic          no_edge_q, no_edge_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [15:0]   trials_q, trials_d;
  logic [6:0]    tap_q, tap_d;
  logic [15:0]   hit_a_q, hit_a_d;
  logic [15:0]   a_only_q, a_only_d;
  logic [11:0]   b_only_q, b_only_d;
  logic          launch_q, launch_d;
  logic          cap_a_q, cap_a_d;
  logic          cap_b_q, cap_b_d;
  logic [31:0]   data_q, data_d;

  logic [1023:0] taps_w;
  logic [9:0]    idx_a, idx_b;

  // Behavioural stand-in for the hand-placed delay cells: tap k of channel c
  // shows the launch level only if its accumulated delay beats one clock.
  for (genvar c = 0; c < P_CHANNELS; c++) begin : g_chan
    for (genvar k = 0; k < P_TAPS; k++) begin : g_tap
      assign taps_w[c*P_TAPS+k] = launch_q & ((k * P_SIM_PS * (c + 1)) < P_CLK_PS);
    end
  end
  if (P_CHANNELS * P_TAPS < 1024) begin : g_pad
    assign taps_w[1023:P_CHANNELS*P_TAPS] = '0;
  end

  assign idx_a  = 10'(cha_q) * 10'(P_TAPS) + 10'(tap_q);
  assign idx_b  = 10'(chb_q) * 10'(P_TAPS) + 10'(tap_q);
  assign o_data = data_q;

  function automatic logic cmd_err(input logic [31:0] c);
    return (c[30:29] == 2'd3) ||
           (32'(c[28:26]) >= P_CHANNELS) ||
           (32'(c[25:23]) >= P_CHANNELS) ||
           (32'(c[22:16]) >= P_TAPS);
  endfunction

  // Next-state, trial bookkeeping and result assembly.
  always_comb begin
    state_d   = state_q;
    tog_d     = tog_q;
    mode_d    = mode_q;
    cha_d     = cha_q;
    chb_d     = chb_q;
    tcnt_d    = tcnt_q;
    err_d     = err_q;
    zero_d    = zero_q;
    no_edge_d = no_edge_q;
    settle_d  = settle_q;
    trials_d  = trials_q;
    tap_d     = tap_q;
    hit_a_d   = hit_a_q;
    a_only_d  = a_only_q;
    b_only_d  = b_only_q;
    cap_a_d   = cap_a_q;
    cap_b_d   = cap_b_q;
    data_d    = data_q;

    case (state_q)
      S_IDLE: begin
        if (i_data[31] != data_q[31]) begin
          tog_d     = i_data[31];
          mode_d    = i_data[30:29];
          cha_d     = i_data[28:26];
          chb_d     = i_data[25:23];
          tap_d     = i_data[22:16];
          tcnt_d    = i_data[15:0];
          trials_d  = i_data[15:0];
          err_d     = cmd_err(i_data);
          zero_d    = (i_data[15:0] == 16'd0);
          no_edge_d = 1'b0;
          hit_a_d   = '0;
          a_only_d  = '0;
          b_only_d  = '0;
          data_d[30] = 1'b1;
          if (cmd_err(i_data) || (i_data[15:0] == 16'd0)) begin
            state_d = S_DONE;
          end else begin
            settle_d = SETTLE_LOAD;
            state_d  = S_ARM;
          end
        end
      end
      S_ARM: begin
        if (settle_q == '0) state_d = S_FIRE;
        else settle_d = settle_q - 1'b1;
      end
      S_FIRE: begin
        cap_a_d = taps_w[idx_a];
        cap_b_d = taps_w[idx_b];
        state_d = S_CAPT;
      end
      S_CAPT: state_d = S_ACC;
      S_ACC: begin
        if (cap_a_q) hit_a_d = hit_a_q + 16'd1;
        if (cap_a_q && !cap_b_q) a_only_d = a_only_q + 16'd1;
        if (cap_b_q && !cap_a_q && (b_only_q != 12'hFFF)) b_only_d = b_only_q + 12'd1;
        trials_d = trials_q - 16'd1;
        if (trials_q == 16'd1) begin
          state_d = (mode_q == 2'd2) ? S_NEXT : S_DONE;
        end else begin
          settle_d = SETTLE_LOAD;
          state_d  = S_ARM;
        end
      end
      S_NEXT: begin
        if (hit_a_q != tcnt_q) begin
          state_d = S_DONE;
        end else if (tap_q == TAP_LAST) begin
          no_edge_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          tap_d    = tap_q + 7'd1;
          hit_a_d  = '0;
          trials_d = tcnt_q;
          settle_d = SETTLE_LOAD;
          state_d  = S_ARM;
        end
      end
      S_DONE: begin
        data_d        = '0;
        data_d[31]    = tog_q;
        data_d[29:28] = mode_q;
        if (err_q) begin
          data_d[24] = 1'b1;
        end else if (!zero_q) begin
          case (mode_q)
            2'd1: begin
              data_d[27:16] = b_only_q;
              data_d[15:0]  = a_only_q;
            end
            2'd2: begin
              data_d[23]    = no_edge_q;
              data_d[22:16] = tap_q;
              data_d[15:0]  = hit_a_q;
            end
            default: begin
              data_d[22:16] = tap_q;
              data_d[15:0]  = hit_a_q;
            end
          endcase
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    launch_d = (state_d == S_FIRE);
  end

  // State and datapath registers; reset abandons any trial in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      tog_q     <= 1'b0;
      mode_q    <= '0;
      cha_q     <= '0;
      chb_q     <= '0;
      tcnt_q    <= '0;
      err_q     <= 1'b0;
      zero_q    <= 1'b0;
      no_edge_q <= 1'b0;
      settle_q  <= '0;
      trials_q  <= '0;
      tap_q     <= '0;
      hit_a_q   <= '0;
      a_only_q  <= '0;
      b_only_q  <= '0;
      launch_q  <= 1'b0;
      cap_a_q   <= 1'b0;
      cap_b_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      tog_q     <= tog_d;
      mode_q    <= mode_d;
      cha_q     <= cha_d;
      chb_q     <= chb_d;
      tcnt_q    <= tcnt_d;
      err_q     <= err_d;
      zero_q    <= zero_d;
      no_edge_q <= no_edge_d;
      settle_q  <= settle_d;
      trials_q  <= trials_d;
      tap_q     <= tap_d;
      hit_a_q   <= hit_a_d;
      a_only_q  <= a_only_d;
      b_only_q  <= b_only_d;
      launch_q  <= launch_d;
      cap_a_q   <= cap_a_d;
      cap_b_q   <= cap_b_d;
      data_q    <= data_d;
    end
  end

endmodule

// File: tb/tb_x_mux_trigger_multi.sv
// Bench for x_mux_trigger_multi: directed and random commands compared
// against a trial-level model of the delay chains and result encoding.
module tb_x_mux_trigger_multi;

  localparam int S  = 4;
  localparam int NC = 4;
  localparam int NT = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_data = '0;
  logic [31:0] o_data;
  logic        tog = 1'b0;
  int          total = 0;
  int          bad = 0;

  x_mux_trigger_multi dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_data (i_data),
    .o_data (o_data)
  );

  always #5 clk = ~clk;

  // A tap hits when its delay (100 ps per cell, scaled by channel+1) is below one 96 MHz period.
  function automatic bit hit(input int ch, input int tp);
    return (tp * 100 * (ch + 1)) < 10417;
  endfunction

  function automatic logic [31:0] mk(input int mode, input int a, input int b, input int tp, input int t);
    logic [31:0] w;
    w = '0;
    w[30:29] = 2'(mode);
    w[28:26] = 3'(a);
    w[25:23] = 3'(b);
    w[22:16] = 7'(tp);
    w[15:0]  = 16'(t);
    return w;
  endfunction

  // Expected status word and cycles from start edge to done edge.
  task automatic model(input logic [31:0] c, output logic [31:0] st, output int lat);
    int mode, a, b, tp, t, k;
    bit ah, bh;
    mode = int'(c[30:29]); a = int'(c[28:26]); b = int'(c[25:23]);
    tp = int'(c[22:16]); t = int'(c[15:0]);
    st = '0; st[31] = c[31]; st[29:28] = c[30:29]; lat = 2;
    if (mode == 3 || a >= NC || b >= NC || tp >= NT) begin
      st[24] = 1'b1;
    end else if (t != 0) begin
      if (mode == 0) begin
        st[22:16] = 7'(tp);
        st[15:0]  = hit(a, tp) ? 16'(t) : 16'd0;
        lat = 2 + t * (S + 3);
      end else if (mode == 1) begin
        ah = hit(a, tp); bh = hit(b, tp);
        st[15:0]  = (ah && !bh) ? 16'(t) : 16'd0;
        st[27:16] = (bh && !ah) ? ((t > 4095) ? 12'hFFF : 12'(t)) : 12'd0;
        lat = 2 + t * (S + 3);
      end else begin
        k = tp;
        forever begin
          lat += t * (S + 3) + 1;
          if (!hit(a, k)) begin
            st[22:16] = 7'(k);
            break;
          end
          if (k == NT - 1) begin
            st[23] = 1'b1; st[22:16] = 7'(k); st[15:0] = 16'(t);
            break;
          end
          k++;
        end
      end
    end
  endtask

  task automatic send(input logic [31:0] body);
    tog = ~tog;
    @(negedge clk);
    i_data = {tog, body[30:0]};
  endtask

  // Follows one command from its start edge (pre edges already elapsed) to its done edge.
  task automatic collect(input logic [31:0] c, input int pre, input string nm);
    logic [31:0] exp;
    int lat, cyc;
    bit seen;
    model(c, exp, lat);
    cyc = pre; seen = 0;
    while (cyc < lat + 50) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        total++;
        if (o_data[30] !== 1'b1) begin
          bad++; $display("FAIL %s busy: got %b want 1", nm, o_data[30]);
        end
      end
      if (o_data[31] === c[31]) begin seen = 1; break; end
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL %s timeout: no done toggle after %0d cycles, want %0d", nm, cyc, lat);
    end else begin
      if (o_data !== exp) begin
        bad++; $display("FAIL %s status: got %h want %h", nm, o_data, exp);
      end
      total++;
      if (cyc != lat) begin
        bad++; $display("FAIL %s latency: got %0d want %0d", nm, cyc, lat);
      end
    end
  endtask

  task automatic run(input logic [31:0] body, input string nm);
    send(body);
    collect({tog, body[30:0]}, 0, nm);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      i_data = $urandom;
      #2;
      total++;
      if (o_data !== 32'd0 || dut.launch_q !== 1'b0) begin
        bad++; $display("FAIL reset: o_data=%h launch=%b want 0/0", o_data, dut.launch_q);
      end
    end
    @(negedge clk);
    i_data = '0; tog = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (o_data !== 32'd0) begin
      bad++; $display("FAIL reset_release: got %h want 0", o_data);
    end
  endtask

  task automatic test_count();
    run(mk(0, 0, 0, 63, 100), "count_ch0_t63");
    run(mk(0, 1, 0, 63, 100), "count_ch1_t63");
    run(mk(0, 3, 0, 0, 5), "count_ch3_t0");
  endtask

  task automatic test_race();
    run(mk(1, 0, 2, 40, 10), "race_a0_b2");
    run(mk(1, 2, 0, 40, 10), "race_a2_b0");
    run(mk(1, 1, 1, 40, 10), "race_tie");
    run(mk(1, 3, 0, 30, 4100), "race_sat");
  endtask

  task automatic test_sweep();
    run(mk(2, 1, 0, 0, 4), "sweep_ch1");
    run(mk(2, 0, 0, 50, 4), "sweep_ch0_noedge");
    run(mk(2, 1, 0, 53, 3), "sweep_ch1_first_miss");
  endtask

  task automatic test_errors();
    run(mk(0, 5, 0, 10, 8), "err_cha");
    run(mk(1, 0, 6, 10, 8), "err_chb");
    run(mk(3, 0, 0, 10, 8), "err_mode3");
    run(mk(0, 0, 0, 100, 8), "err_tap");
    run(mk(0, 0, 0, 10, 0), "t_zero");
  endtask

  task automatic test_back_to_back();
    logic [31:0] ca, cb;
    ca = mk(2, 1, 0, 50, 2);
    cb = mk(1, 0, 3, 20, 3);
    send(ca);
    ca[31] = tog;
    repeat (3) @(negedge clk);
    tog = ~tog;
    i_data = {tog, cb[30:0]};
    cb[31] = tog;
    collect(ca, 3, "queue_first");
    collect(cb, 0, "queue_second");
  endtask

  task automatic test_reset_mid();
    send(mk(2, 1, 0, 0, 4));
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    i_data = '0; tog = 1'b0;
    #2;
    total++;
    if (o_data !== 32'd0 || dut.launch_q !== 1'b0) begin
      bad++; $display("FAIL reset_mid: o_data=%h launch=%b want 0/0", o_data, dut.launch_q);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (o_data !== 32'd0) begin
      bad++; $display("FAIL reset_mid_idle: got %h want 0", o_data);
    end
    run(mk(0, 2, 0, 17, 6), "after_reset");
  endtask

  task automatic test_random();
    int r, mode, a, b, tp, t;
    for (int n = 0; n < 14; n++) begin
      r = $urandom_range(0, 9);
      mode = (r < 4) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
      a = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
      b = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
      tp = (mode == 2) ? $urandom_range(40, 63)
         : ($urandom_range(0, 9) == 0) ? $urandom_range(64, 127) : $urandom_range(0, 63);
      t = $urandom_range(0, 12);
      run(mk(mode, a, b, tp, t), $sformatf("rand%0d", n));
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_race();
    test_sweep();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
